// File: rtl/axi_mm_pkg.sv
// Shared AXI4 memory-mapped constants, write-master FSM states and sizing helper.
package axi_mm_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam int AXI_4K_BYTES = 4096;

  // Normal non-cacheable bufferable memory.
  localparam logic [3:0] AXI_CACHE_NC_BUF = 4'b0011;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_DRAIN,
    ST_STATUS
  } axi_wr_state_t;

  // AXI size encoding: log2 of the bytes carried by one beat.
  function automatic logic [2:0] axi_size(input int data_width);
    return 3'($clog2(data_width / 8));
  endfunction

endpackage

// File: rtl/axi_mm_if.sv
// AXI4 memory-mapped bundle with master and slave views.
interface axi_mm #(
  parameter int ADDR_WIDTH = 33,
  parameter int DATA_WIDTH = 512
);

  logic                    awvalid;
  logic                    awready;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic [3:0]              awcache;
  logic                    awlock;
  logic [2:0]              awprot;
  logic [3:0]              awqos;
  logic [3:0]              awregion;

  logic                    wvalid;
  logic                    wready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;

  logic                    bvalid;
  logic                    bready;
  logic [1:0]              bresp;

  logic                    arvalid;
  logic                    arready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;

  logic                    rvalid;
  logic                    rready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;

  modport master (
    output awvalid, awaddr, awlen, awsize, awburst, awcache, awlock, awprot, awqos, awregion,
    input  awready,
    output wvalid, wdata, wstrb, wlast,
    input  wready,
    input  bvalid, bresp,
    output bready,
    output arvalid, araddr, arlen, arsize, arburst,
    input  arready,
    input  rvalid, rdata, rresp, rlast,
    output rready
  );

  modport slave (
    input  awvalid, awaddr, awlen, awsize, awburst, awcache, awlock, awprot, awqos, awregion,
    output awready,
    input  wvalid, wdata, wstrb, wlast,
    output wready,
    output bvalid, bresp,
    input  bready,
    input  arvalid, araddr, arlen, arsize, arburst,
    output arready,
    output rvalid, rdata, rresp, rlast,
    input  rready
  );

endinterface

// File: rtl/axi_burst_calc.sv
// Sizes the next INCR burst: the smallest of beats left, the burst cap and the
// beats remaining before the next 4 KiB boundary.
module axi_burst_calc
  import axi_mm_pkg::*;
#(
  parameter int DATA_WIDTH      = 512,
  parameter int MAX_BURST_BEATS = 64,
  parameter int BEATS_W         = 26
) (
  input  logic [11:0]        i_addr_lo,
  input  logic [BEATS_W-1:0] i_beats_left,
  output logic [8:0]         o_burst,
  output logic [7:0]         o_awlen
);

  localparam int         SZ        = int'(axi_size(DATA_WIDTH));
  localparam logic [8:0] MAX_BEATS = 9'(MAX_BURST_BEATS);

  logic [12:0] w_bytes_to_4k;
  logic [8:0]  w_beats_to_4k;
  logic [8:0]  w_cap;

  always_comb begin
    w_bytes_to_4k = 13'(AXI_4K_BYTES) - {1'b0, i_addr_lo};
    w_beats_to_4k = 9'(w_bytes_to_4k >> SZ);
    w_cap         = (w_beats_to_4k < MAX_BEATS) ? w_beats_to_4k : MAX_BEATS;
    o_burst       = (i_beats_left < BEATS_W'(w_cap)) ? 9'(i_beats_left) : w_cap;
    o_awlen       = 8'(o_burst - 9'd1);
  end

endmodule

// File: rtl/axi_mm_write_master.sv
// Write-only AXI4 burst master: turns (addr, len) plus a stream payload into
// 4 KiB-safe INCR bursts and reports the worst write response per command.
module axi_mm_write_master
  import axi_mm_pkg::*;
#(
  parameter int DATA_WIDTH      = 512,
  parameter int ADDR_WIDTH      = 33,
  parameter int MAX_BURST_BEATS = 64,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [31:0]           cmd_len,

  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,

  axi_mm.master                 m_axi,

  output logic                  sts_valid,
  input  logic                  sts_ready,
  output logic [1:0]            sts_resp
);

  localparam logic [2:0] AW_SIZE = axi_size(DATA_WIDTH);
  localparam int         SZ      = int'(AW_SIZE);
  localparam int         BEATS_W = 32 - SZ;
  localparam int         OUT_W   = $clog2(MAX_OUTSTANDING + 1);

  axi_wr_state_t        r_state;
  axi_wr_state_t        w_state_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [BEATS_W-1:0]   r_beats_left;
  logic [8:0]           r_beat_cnt;
  logic [8:0]           r_burst;
  logic [OUT_W-1:0]     r_outstanding;
  logic [OUT_W-1:0]     w_outstanding_next;
  logic [1:0]           r_resp_acc;

  logic [8:0]           w_burst;
  logic [7:0]           w_awlen;
  logic                 w_cmd_hs;
  logic                 w_aw_hs;
  logic                 w_w_hs;
  logic                 w_last_hs;
  logic                 w_b_hs;

  axi_burst_calc #(
    .DATA_WIDTH      (DATA_WIDTH),
    .MAX_BURST_BEATS (MAX_BURST_BEATS),
    .BEATS_W         (BEATS_W)
  ) u_burst_calc (
    .i_addr_lo    (r_addr[11:0]),
    .i_beats_left (r_beats_left),
    .o_burst      (w_burst),
    .o_awlen      (w_awlen)
  );

  assign cmd_ready = (r_state == ST_IDLE) && !rst;

  assign m_axi.awvalid  = (r_state == ST_ADDR) && (r_outstanding < OUT_W'(MAX_OUTSTANDING));
  assign m_axi.awaddr   = r_addr;
  assign m_axi.awlen    = w_awlen;
  assign m_axi.awsize   = AW_SIZE;
  assign m_axi.awburst  = AXI_BURST_INCR;
  assign m_axi.awcache  = AXI_CACHE_NC_BUF;
  assign m_axi.awlock   = 1'b0;
  assign m_axi.awprot   = 3'd0;
  assign m_axi.awqos    = 4'd0;
  assign m_axi.awregion = 4'd0;

  // The W channel is a straight pass-through of the stream while in DATA.
  assign m_axi.wvalid   = (r_state == ST_DATA) && s_axis_tvalid;
  assign s_axis_tready  = (r_state == ST_DATA) && m_axi.wready;
  assign m_axi.wdata    = s_axis_tdata;
  assign m_axi.wstrb    = '1;
  assign m_axi.wlast    = (r_state == ST_DATA) && (r_beat_cnt == 9'd1);

  assign m_axi.bready   = 1'b1;

  assign m_axi.arvalid  = 1'b0;
  assign m_axi.araddr   = '0;
  assign m_axi.arlen    = 8'd0;
  assign m_axi.arsize   = AW_SIZE;
  assign m_axi.arburst  = AXI_BURST_INCR;
  assign m_axi.rready   = 1'b1;

  assign sts_valid = (r_state == ST_STATUS);
  assign sts_resp  = r_resp_acc;

  assign w_cmd_hs  = cmd_valid && cmd_ready;
  assign w_aw_hs   = m_axi.awvalid && m_axi.awready;
  assign w_w_hs    = m_axi.wvalid && m_axi.wready;
  assign w_last_hs = w_w_hs && m_axi.wlast;
  assign w_b_hs    = m_axi.bvalid;

  // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_outstanding_next = r_outstanding;
    if (w_aw_hs && !w_b_hs) begin
      w_outstanding_next = r_outstanding + OUT_W'(1);
    end else if (!w_aw_hs && w_b_hs) begin
      w_outstanding_next = r_outstanding - OUT_W'(1);
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE:   if (w_cmd_hs) w_state_next = ST_ADDR;
      ST_ADDR:   if (w_aw_hs)  w_state_next = ST_DATA;
      ST_DATA: begin
        if (w_last_hs) begin
          w_state_next = (r_beats_left == BEATS_W'(r_burst)) ? ST_DRAIN : ST_ADDR;
        end
      end
      // Leave as soon as the final response lands, even in this very cycle.
      ST_DRAIN:  if (w_outstanding_next == '0) w_state_next = ST_STATUS;
      ST_STATUS: if (sts_ready) w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_addr        <= '0;
      r_beats_left  <= '0;
      r_beat_cnt    <= '0;
      r_burst       <= '0;
      r_outstanding <= '0;
      r_resp_acc    <= AXI_RESP_OKAY;
    end else begin
      r_state       <= w_state_next;
      r_outstanding <= w_outstanding_next;

      if (w_cmd_hs) begin
        r_addr       <= cmd_addr;
        r_beats_left <= BEATS_W'(cmd_len >> SZ);
        r_resp_acc   <= AXI_RESP_OKAY;
      end else if (w_b_hs && (m_axi.bresp > r_resp_acc)) begin
        r_resp_acc   <= m_axi.bresp;
      end

      if (w_aw_hs) begin
        r_beat_cnt <= w_burst;
        r_burst    <= w_burst;
      end else if (w_w_hs) begin
        r_beat_cnt <= r_beat_cnt - 9'd1;
      end

      if (w_last_hs) begin
        r_addr       <= r_addr + (ADDR_WIDTH'(r_burst) << SZ);
        r_beats_left <= r_beats_left - BEATS_W'(r_burst);
      end
    end
  end

endmodule

// File: tb/tb_axi_mm_write_master.sv
// Directed bench for axi_mm_write_master: a reference burst model and payload
// scoreboard are filled when commands are issued and drained by channel monitors.
module tb_axi_mm_write_master;
  import axi_mm_pkg::*;

  localparam int DW    = 512;
  localparam int AW    = 33;
  localparam int MAXB  = 64;
  localparam int MAXO  = 8;
  localparam int BYTES = DW / 8;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    len;
  } aw_exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [31:0]   cmd_len;
  logic          tvalid;
  logic          tready;
  logic [DW-1:0] tdata;
  logic          sts_valid;
  logic          sts_ready;
  logic [1:0]    sts_resp;

  axi_mm #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m_axi ();

  axi_mm_write_master #(
    .DATA_WIDTH      (DW),
    .ADDR_WIDTH      (AW),
    .MAX_BURST_BEATS (MAXB),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_addr      (cmd_addr),
    .cmd_len       (cmd_len),
    .s_axis_tvalid (tvalid),
    .s_axis_tready (tready),
    .s_axis_tdata  (tdata),
    .m_axi         (m_axi),
    .sts_valid     (sts_valid),
    .sts_ready     (sts_ready),
    .sts_resp      (sts_resp)
  );

  always #5 clk = ~clk;

  int      checks = 0;
  int      errors = 0;
  aw_exp_t exp_aw_q[$];
  logic [DW-1:0] src_q[$];
  logic [DW-1:0] exp_w_q[$];
  int      burst_len_q[$];
  logic [1:0] resp_plan_q[$];
  logic [1:0] b_pend_q[$];
  int      w_rem = 0;
  bit      stall_en = 1'b0;
  bit      b_hold = 1'b0;
  int      aw_count = 0;
  int      w_count = 0;
  int      wlast_count = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference burst split plus payload generation for one command.
  task automatic load_cmd(input logic [AW-1:0] addr, input int unsigned len);
    longint unsigned a;
    int unsigned     left;
    int unsigned     to4k;
    int unsigned     b;
    aw_exp_t         e;
    logic [DW-1:0]   d;
    a    = addr;
    left = len / BYTES;
    while (left > 0) begin
      to4k = (4096 - int'(a % 4096)) / BYTES;
      b = left;
      if (b > MAXB) b = MAXB;
      if (b > to4k) b = to4k;
      e.addr = AW'(a);
      e.len  = 8'(b - 1);
      exp_aw_q.push_back(e);
      a    = a + b * BYTES;
      left = left - b;
    end
    for (int i = 0; i < int'(len / BYTES); i++) begin
      for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = $urandom();
      src_q.push_back(d);
      exp_w_q.push_back(d);
    end
  endtask

  task automatic send_cmd(input logic [AW-1:0] addr, input int unsigned len);
    int n;
    load_cmd(addr, len);
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_addr  = addr;
    cmd_len   = len;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("cmd_ready", cmd_ready, 1'b1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_status(input logic [1:0] exp_resp, input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (!sts_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("sts_valid", sts_valid, 1'b1);
    check("sts_resp", sts_resp, exp_resp);
    check("aw_all_issued", exp_aw_q.size(), 0);
    check("w_all_seen", exp_w_q.size(), 0);
    repeat (2) @(negedge clk);
    check("sts_hold", {sts_valid, sts_resp}, {1'b1, exp_resp});
    @(posedge clk); #1;
    sts_ready = 1'b1;
    @(posedge clk); #1;
    sts_ready = 1'b0;
    @(negedge clk);
    check("sts_drop", sts_valid, 1'b0);
    check("idle_ready", cmd_ready, 1'b1);
  endtask

  task automatic clear_counts();
    aw_count    = 0;
    w_count     = 0;
    wlast_count = 0;
  endtask

  // AW and W monitors; W beats against the scoreboard, wlast against the burst model.
  initial begin
    aw_exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (m_axi.awvalid && m_axi.awready) begin
          aw_count++;
          if (exp_aw_q.size() == 0) begin
            check("aw_expected_pending", exp_aw_q.size(), 1);
          end else begin
            e = exp_aw_q.pop_front();
            check("awaddr", m_axi.awaddr, e.addr);
            check("awlen", m_axi.awlen, e.len);
            check("aw_fixed",
                  {m_axi.awsize, m_axi.awburst, m_axi.awcache, m_axi.awlock,
                   m_axi.awprot, m_axi.awqos, m_axi.awregion},
                  {3'd6, AXI_BURST_INCR, 4'b0011, 1'b0, 3'd0, 4'd0, 4'd0});
            burst_len_q.push_back(int'(e.len) + 1);
          end
        end
        if (m_axi.wvalid && m_axi.wready) begin
          w_count++;
          if (w_rem == 0 && burst_len_q.size() > 0) w_rem = burst_len_q.pop_front();
          if (exp_w_q.size() == 0) begin
            check("w_expected_pending", exp_w_q.size(), 1);
          end else begin
            check("wdata", m_axi.wdata, exp_w_q.pop_front());
          end
          check("wlast", m_axi.wlast, w_rem == 1);
          check("wstrb", m_axi.wstrb, {BYTES{1'b1}});
          if (w_rem > 0) w_rem--;
          if (m_axi.wlast) begin
            wlast_count++;
            b_pend_q.push_back((resp_plan_q.size() > 0) ? resp_plan_q.pop_front() : AXI_RESP_OKAY);
          end
        end
      end
    end
  end

  // Stream source: holds tvalid until accepted, optional random gaps.
  initial begin
    bit hs;
    tvalid = 1'b0;
    tdata  = '0;
    forever begin
      @(negedge clk);
      hs = tvalid && tready && !rst;
      @(posedge clk); #1;
      if (hs && src_q.size() > 0) void'(src_q.pop_front());
      if (src_q.size() == 0) tvalid = 1'b0;
      else if (!(tvalid && !hs)) tvalid = !stall_en || ($urandom_range(1) == 1);
      tdata = (src_q.size() > 0) ? src_q[0] : '0;
    end
  end

  // Slave ready generation.
  initial begin
    forever begin
      @(posedge clk); #1;
      m_axi.wready  = !stall_en || ($urandom_range(1) == 1);
      m_axi.awready = !stall_en || ($urandom_range(1) == 1);
    end
  end

  // B responder: one response per completed burst, optionally withheld.
  initial begin
    bit hs;
    m_axi.bvalid = 1'b0;
    m_axi.bresp  = AXI_RESP_OKAY;
    forever begin
      @(negedge clk);
      hs = m_axi.bvalid && m_axi.bready && !rst;
      @(posedge clk); #1;
      if (hs && b_pend_q.size() > 0) void'(b_pend_q.pop_front());
      if (!b_hold && b_pend_q.size() > 0) begin
        m_axi.bvalid = 1'b1;
        m_axi.bresp  = b_pend_q[0];
      end else begin
        m_axi.bvalid = 1'b0;
        m_axi.bresp  = AXI_RESP_OKAY;
      end
    end
  end

  initial begin
    int  beats;
    int  n;
    bit  seen;
    rst           = 1'b1;
    cmd_valid     = 1'b0;
    cmd_addr      = '0;
    cmd_len       = '0;
    sts_ready     = 1'b0;
    m_axi.awready = 1'b1;
    m_axi.wready  = 1'b1;
    m_axi.arready = 1'b0;
    m_axi.rvalid  = 1'b0;
    m_axi.rdata   = '0;
    m_axi.rresp   = AXI_RESP_OKAY;
    m_axi.rlast   = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1'b0);
    check("rst_valids", {m_axi.awvalid, m_axi.wvalid, tready, sts_valid}, 4'b0000);
    check("rst_sts_resp", sts_resp, 2'b00);
    check("rst_outstanding", dut.r_outstanding, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle_cmd_ready", cmd_ready, 1'b1);
    check("tieoffs", {m_axi.bready, m_axi.rready, m_axi.arvalid}, 3'b110);

    // 1: single full burst.
    clear_counts();
    send_cmd(33'h1000, 4096);
    @(negedge clk);
    check("aw_rise_next_cycle", m_axi.awvalid, 1'b1);
    wait_status(AXI_RESP_OKAY, 1000);
    check("t1_aw_count", aw_count, 1);
    check("t1_w_count", w_count, 64);
    check("t1_wlast_count", wlast_count, 1);

    // 2: 4 KiB boundary split.
    clear_counts();
    send_cmd(33'h0FC0, 128);
    wait_status(AXI_RESP_OKAY, 200);
    check("t2_aw_count", aw_count, 2);
    check("t2_wlast_count", wlast_count, 2);

    // 3: outstanding limit with B withheld, then release.
    clear_counts();
    b_hold = 1'b1;
    send_cmd(33'h0, 32'h0010_0000);
    repeat (800) @(negedge clk);
    check("t3_aw_at_limit", aw_count, MAXO);
    check("t3_outstanding", dut.r_outstanding, MAXO);
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      seen = seen | m_axi.awvalid;
    end
    check("t3_awvalid_blocked", seen, 1'b0);
    @(posedge clk); #1;
    b_hold = 1'b0;
    wait_status(AXI_RESP_OKAY, 40000);
    check("t3_aw_count", aw_count, 256);
    check("t3_w_count", w_count, 16384);
    check("t3_wlast_count", wlast_count, 256);

    // 4: random stalls on both sides.
    clear_counts();
    stall_en = 1'b1;
    send_cmd(33'h4_0000, 8192);
    wait_status(AXI_RESP_OKAY, 3000);
    check("t4_w_count", w_count, 128);
    check("t4_wlast_count", wlast_count, 2);
    @(posedge clk); #1;
    stall_en = 1'b0;

    // 5: worst response accumulation.
    resp_plan_q = '{AXI_RESP_OKAY, AXI_RESP_SLVERR, AXI_RESP_OKAY};
    send_cmd(33'h8_0000, 12288);
    wait_status(AXI_RESP_SLVERR, 1000);
    resp_plan_q = '{AXI_RESP_OKAY, AXI_RESP_SLVERR, AXI_RESP_DECERR};
    send_cmd(33'hC_0000, 12288);
    wait_status(AXI_RESP_DECERR, 1000);

    // 6: reset in the middle of a burst on beat 10.
    clear_counts();
    send_cmd(33'h2000, 4096);
    beats = 0;
    n = 0;
    while (beats < 10 && n < 500) begin
      @(negedge clk);
      if (m_axi.wvalid && m_axi.wready) beats++;
      n++;
    end
    check("t6_beat10_reached", beats, 10);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    src_q.delete();
    exp_w_q.delete();
    exp_aw_q.delete();
    burst_len_q.delete();
    b_pend_q.delete();
    resp_plan_q.delete();
    w_rem = 0;
    check("t6_cmd_ready_in_rst", cmd_ready, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("t6_valids_after_rst", {m_axi.awvalid, m_axi.wvalid, tready, sts_valid}, 4'b0000);
    check("t6_outstanding", dut.r_outstanding, 0);
    check("t6_idle", cmd_ready, 1'b1);
    clear_counts();
    send_cmd(33'h3040, 320);
    wait_status(AXI_RESP_OKAY, 500);
    check("t6_aw_count", aw_count, 1);
    check("t6_w_count", w_count, 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi_mm_write_master.md
# axi_mm_write_master

Write-only AXI4 memory-mapped burst master. It converts a (address, length) command plus a beat-aligned AXI-Stream payload into legal AXI4 INCR write bursts, then reports completion. It sits directly upstream of the AXI clock converter: its `m_axi` port drives the converter's slave side in the user clock domain.

## Interface
Parameters:
- `DATA_WIDTH`, 512: AXI/stream data width in bits; must be 256 or 512.
- `ADDR_WIDTH`, 33: AXI address width.
- `MAX_BURST_BEATS`, 64: upper bound on beats per burst, 1..256.
- `MAX_OUTSTANDING`, 8: maximum number of bursts awaiting a B response.

Ports (one clock; reset is synchronous and active-high):
- `clk` input 1: sole clock.
- `rst` input 1: synchronous, active-high reset.
- `cmd_valid` input 1; `cmd_ready` output 1: command handshake.
- `cmd_addr` input ADDR_WIDTH: start byte address; must be beat-aligned.
- `cmd_len` input 32: byte count. Nonzero and a multiple of DATA_WIDTH/8; the low log2(DATA_WIDTH/8) bits are ignored.
- `s_axis_tvalid` input 1; `s_axis_tready` output 1; `s_axis_tdata` input DATA_WIDTH: payload beats. `tkeep`/`tlast` are not used.
- `m_axi` axi_mm.master: AXI4 write channels driven; read channels tied off (`arvalid`=0, `rready`=1).
- `sts_valid` output 1; `sts_ready` input 1; `sts_resp` output 2: completion handshake and worst `bresp` of the command.

## Operation
- FSM states: IDLE, ADDR, DATA, DRAIN, STATUS.
- IDLE: `cmd_ready`=1. On handshake:
  - latch `addr`;
  - `beats_left` = `cmd_len` >> log2(DATA_WIDTH/8);
  - clear `resp_acc`;
  - go to ADDR.
- ADDR: compute `burst` = min(`beats_left`, MAX_BURST_BEATS, beats remaining to the next 4 KiB boundary).
  - Drive `awaddr`=`addr`, `awlen`=`burst`-1, `awsize`=log2(DATA_WIDTH/8), `awburst`=INCR (01), `awcache`=0011.
  - `awlock`, `awprot`, `awqos`, `awregion` are 0.
  - Assert `awvalid` only while `outstanding` < MAX_OUTSTANDING.
  - On the AW handshake: `outstanding`++, load `beat_cnt`=`burst`, go to DATA.
- DATA: `wvalid`=`s_axis_tvalid`; `s_axis_tready`=`wready`; `wdata`=`tdata`; `wstrb` is all ones; `wlast`=(`beat_cnt`==1).
  - Each W handshake: `beat_cnt`--.
  - On the `wlast` handshake: `addr`+=`burst`·bytes, `beats_left`-=`burst`.
  - Then go to ADDR if `beats_left`≠0, else DRAIN.
- B channel, in every state: `bready`=1.
  - Each `bvalid`: `outstanding`--, `resp_acc`=max(`resp_acc`, `bresp`).
  - An AW handshake and a B response in the same cycle leave `outstanding` unchanged.
- DRAIN: wait until `outstanding`==0, including a B response arriving that cycle; then go to STATUS.
- STATUS: `sts_valid`=1, `sts_resp`=`resp_acc`. On the handshake, go to IDLE.
- Width rules:
  - 4 KiB-remaining beats = (4096 − `addr`[11:0]) / bytes.
  - `beats_left` holds 32 − log2(bytes) bits; `burst` holds 9 bits.
  - No address wrap check: crossing 2^ADDR_WIDTH is undefined.

## Timing
- Reset values: `cmd_ready`=0 during reset, then 1 in IDLE. `awvalid`, `wvalid`, `s_axis_tready`, `sts_valid`=0; `sts_resp`=0; `outstanding`=0.
- `bready`=1 and `rready`=1 from the first cycle after reset.
- `awvalid` first rises the cycle after `cmd_valid`·`cmd_ready`. All AW fields are registered and held stable while `awvalid`=1 and `awready`=0.
- The W path is combinational from the stream: zero latency, no buffering.
- Burst-to-burst gap: one cycle (DATA→ADDR), with the next AW issued the following cycle.
- `sts_valid` rises no earlier than the cycle after the last B handshake.
- `sts_valid` and `sts_resp` are held until `sts_ready`.
- Reset mid-operation: abandon all state immediately. Downstream must be reset in the same window; partial bursts are not completed.

## Structure
- Shared package `axi_mm_pkg`:
  - constants `AXI_BURST_INCR`, `AXI_RESP_OKAY`/`EXOKAY`/`SLVERR`/`DECERR`, `AXI_4K_BYTES`;
  - the FSM state enum `axi_wr_state_t`;
  - function `axi_size(DATA_WIDTH)`.
- One natural sub-module: `axi_burst_calc`. It is combinational: from `addr`, `beats_left` and the parameters it produces `burst` and `awlen`.

## Test plan
1. DATA_WIDTH=512, addr 0x1000, len 4096: one AW with `awlen`=63, `awsize`=6; 64 W beats; `wlast` on beat 64; `sts_resp`=0.
2. addr 0x0FC0, len 128: two AWs, (0x0FC0, `awlen` 0) then (0x1000, `awlen` 0), each with a single `wlast` beat.
3. len 1 MiB from 0x0, MAX_OUTSTANDING=8, `bvalid` withheld: exactly 8 AWs issued, then `awvalid` stays 0. Release B responses: all 256 bursts complete and exactly 16384 beats are transferred.
4. Random `wready` and `tvalid` stalls (50 %), len 8192: data order preserved, no duplicated or lost beat, `wlast` count = 2.
5. Three-burst command with `bresp`=SLVERR on the second burst: `sts_resp`=2. With DECERR also on the third burst: `sts_resp`=3.
6. Assert `rst` during DATA on beat 10: the next cycle all valids are 0 and `outstanding`=0. A new command then completes normally.
